// File: rtl/msrv32_integer_file_pkg.sv
// Shared msrv32 constants used by the integer register file and its read ports.
package msrv32_integer_file_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;
endpackage

// File: rtl/msrv32_integer_file_rf_read_port.sv
// One combinational read port: x0 reads zero, then same-cycle write bypass, then storage.
module msrv32_rf_read_port
  import msrv32_integer_file_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                  addr_i,
  input  logic [ADDR_W-1:0]                  rd_addr_i,
  input  logic                               wr_en_i,
  input  logic [XLEN_P-1:0]                  rd_data_i,
  input  logic [NUM_REGS_P-1:0][XLEN_P-1:0]  regs_i,
  output logic [XLEN_P-1:0]                  data_o
);

  always_comb begin
    data_o = '0;
    if (addr_i == X0_ADDR) begin
      data_o = '0;
    end else if (wr_en_i && (addr_i == rd_addr_i)) begin
      data_o = rd_data_i;
    end else begin
      data_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/msrv32_integer_file.sv
// Architectural integer register file x0..x31 with two bypassed combinational read ports.
module msrv32_integer_file
  import msrv32_integer_file_pkg::*;
#(
  parameter int XLEN_P     = XLEN,
  parameter int NUM_REGS_P = NUM_REGS,
  parameter int ADDR_W     = REG_ADDR_W
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN_P-1:0] rd_in,
  output logic [XLEN_P-1:0] rs_1_out,
  output logic [XLEN_P-1:0] rs_2_out
);

  logic [NUM_REGS_P-1:1][XLEN_P-1:0] regs_q;
  logic [NUM_REGS_P-1:1][XLEN_P-1:0] regs_d;
  logic [NUM_REGS_P-1:0][XLEN_P-1:0] regs_view;
  logic                              wr_en_eff;

  // Reset suppresses both the write and the bypass; storage is already zero under reset.
  assign wr_en_eff = wr_en_in & ~ms_riscv32_mp_rst_in;
  assign regs_view = {regs_q, {XLEN_P{1'b0}}};

  always_comb begin
    regs_d = regs_q;
    if (wr_en_eff && (rd_addr_in != X0_ADDR)) begin
      regs_d[rd_addr_in] = rd_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  msrv32_rf_read_port #(
    .XLEN_P(XLEN_P), .NUM_REGS_P(NUM_REGS_P), .ADDR_W(ADDR_W)
  ) u_rs1_port (
    .addr_i    (rs_1_addr_in),
    .rd_addr_i (rd_addr_in),
    .wr_en_i   (wr_en_eff),
    .rd_data_i (rd_in),
    .regs_i    (regs_view),
    .data_o    (rs_1_out)
  );

  msrv32_rf_read_port #(
    .XLEN_P(XLEN_P), .NUM_REGS_P(NUM_REGS_P), .ADDR_W(ADDR_W)
  ) u_rs2_port (
    .addr_i    (rs_2_addr_in),
    .rd_addr_i (rd_addr_in),
    .wr_en_i   (wr_en_eff),
    .rd_data_i (rd_in),
    .regs_i    (regs_view),
    .data_o    (rs_2_out)
  );

endmodule
